dmem_responder: RTL and testbench

Memory-side responder for the core's data-memory load/store port: accepts one request at a time over a valid/ready handshake, checks alignment and range, inserts a fixed number of wait states, performs a byte-lane-masked read or write, and returns a response over a second valid/ready handshake. It sits behind the memory-access stage as the slave end of the core's dmem interface, and replaces the zero-latency array for multi-cycle memory modelling.

---
 rtl/dmem_responder_pkg.sv | 31 +++
 rtl/dmem_responder_array.sv | 30 +++
 rtl/dmem_responder.sv | 101 ++++++++++
 tb/tb_dmem_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: state encoding,
// widths and the byte-enable legality rule.
package dmem_responder_pkg;

    localparam int DMEM_DATA_WIDTH = 32;
    localparam int BE_WIDTH        = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } rsp_state_t;

    // Single lanes must match the byte offset; halves and words must be naturally aligned.
    function automatic logic be_legal(input logic [BE_WIDTH-1:0] be, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (be)
            4'b0001: ok = (off == 2'd0);
            4'b0010: ok = (off == 2'd1);
            4'b0100: ok = (off == 2'd2);
            4'b1000: ok = (off == 2'd3);
            4'b0011: ok = (off == 2'd0);
            4'b1100: ok = (off == 2'd2);
            4'b1111: ok = (off == 2'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port word RAM with per-byte write enables; the registered read
// returns the word as it was before a write on the same edge.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                         clk,
    input  logic                         en,
    input  logic                         we,
    input  logic [BE_WIDTH-1:0]          be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [DMEM_DATA_WIDTH-1:0]   wdata,
    output logic [DMEM_DATA_WIDTH-1:0]   rdata
);

    logic [DMEM_DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int k = 0; k < BE_WIDTH; k++) begin
                if (we && be[k]) begin
                    mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle slave for the core's dmem port: one request at a time, fixed
// wait states, alignment/range checking and a held response handshake.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    rsp_state_t  state, state_next;
    logic [3:0]  cnt;
    logic        we_q, err_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;

    logic        accept, commit, req_err;
    logic        src_we, src_err;
    logic [31:0] src_addr, src_wdata;
    logic [3:0]  src_be;
    logic [31:0] arr_rdata;

    assign req_ready = (state == ST_IDLE) && reset;
    assign accept    = req_valid && req_ready;
    assign req_err   = !be_legal(req_be, req_addr[1:0]) || (|req_addr[31:AW+2]);

    // With zero wait states the access commits on the accepting edge, straight from the request bus.
    assign src_we    = (state == ST_IDLE) ? req_we    : we_q;
    assign src_addr  = (state == ST_IDLE) ? req_addr  : addr_q;
    assign src_wdata = (state == ST_IDLE) ? req_wdata : wdata_q;
    assign src_be    = (state == ST_IDLE) ? req_be    : be_q;
    assign src_err   = (state == ST_IDLE) ? req_err   : err_q;
    assign commit    = ((state == ST_IDLE) && accept && (WAIT_STATES == 0)) ||
                       ((state == ST_WAIT) && (cnt == 4'd1));

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .en    (commit),
        .we    (src_we && !src_err),
        .be    (src_be),
        .addr  (src_addr[AW+1:2]),
        .wdata (src_wdata),
        .rdata (arr_rdata)
    );

    assign rsp_valid = (state == ST_RESP);
    assign rsp_err   = (state == ST_RESP) && err_q;
    assign rsp_rdata = ((state == ST_RESP) && !we_q && !err_q) ? arr_rdata : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            err_q <= 1'b0;
            we_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt   <= WAIT_INIT;
                err_q <= req_err;
                we_q  <= req_we;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt == 4'd1) state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-level memory model;
// a second instance exercises the zero-wait-state build.
module tb_dmem_responder;

    localparam int WS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] ref_mem [256];

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut_zero (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(1'b1),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_err(input logic [31:0] addr, input logic [3:0] be);
        int  off;
        logic ok;
        off = int'(addr[1:0]);
        ok  = 1'b0;
        if (be == 4'b1111 || be == 4'b0011) ok = (off == 0);
        else if (be == 4'b1100)             ok = (off == 2);
        else if ($countones(be) == 1)       ok = be[off];
        if ((addr >> 2) >= 32'd256) ok = 1'b0;
        return !ok;
    endfunction

    task automatic ref_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output logic [31:0] rdata, output logic err);
        logic [31:0] w;
        err   = ref_err(addr, be);
        rdata = 32'd0;
        if (!err) begin
            w = ref_mem[addr[9:2]];
            if (we) begin
                for (int k = 0; k < 4; k++)
                    if (be[k]) w[8*k +: 8] = wdata[8*k +: 8];
                ref_mem[addr[9:2]] = w;
            end else begin
                rdata = w;
            end
        end
    endtask

    task automatic run_tx(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold, input string tag);
        logic [31:0] exp_rd, r0;
        logic        exp_err, e0;
        int          lat;
        ref_access(we, addr, wdata, be, exp_rd, exp_err);
        @(negedge clk);
        check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_be = 4'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 40);
        check_eq({tag, "_latency"}, 64'(lat), 64'(WS + 1));
        if (rsp_valid) begin
            r0 = rsp_rdata;
            e0 = rsp_err;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_eq({tag, "_hold"}, {rsp_valid, rsp_err, req_ready, rsp_rdata},
                         {1'b1, e0, 1'b0, r0});
            end
            rsp_ready = 1'b1;
            check_eq({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
            check_eq({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            @(negedge clk);
            check_eq({tag, "_one_hs"}, {rsp_valid, req_ready}, 2'b01);
        end
    endtask

    logic [3:0]  be_tab [9];
    logic [31:0] a, v;
    logic [29:0] word;

    initial begin
        be_tab[0] = 4'b0001; be_tab[1] = 4'b0010; be_tab[2] = 4'b0100; be_tab[3] = 4'b1000;
        be_tab[4] = 4'b0011; be_tab[5] = 4'b1100; be_tab[6] = 4'b1111; be_tab[7] = 4'b0000;
        be_tab[8] = 4'b0110;
        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata}, 35'd0);
        check_eq("reset_outputs_zero", {z_req_ready, z_rsp_valid, z_rsp_err, z_rsp_rdata}, 35'd0);
        reset = 1'b1;
        #1;
        check_eq("ready_after_reset", 64'(req_ready), 64'd1);

        for (int w = 0; w < 16; w++) run_tx(1'b1, 32'(w * 4), $urandom, 4'hF, 0, "init");

        run_tx(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, "st_word");
        run_tx(1'b0, 32'h10, 32'h0,        4'b1111, 0, "ld_word");
        run_tx(1'b1, 32'h11, 32'h0000AA00, 4'b0010, 0, "st_byte");
        run_tx(1'b1, 32'h12, 32'h12340000, 4'b1100, 0, "st_half");
        run_tx(1'b0, 32'h10, 32'h0,        4'b1111, 0, "ld_merge");
        check_eq("merge_model", 64'(ref_mem[4]), 64'h1234AAEF);
        run_tx(1'b1, 32'h13, 32'hFFFFFFFF, 4'b0011, 0, "st_misalign");
        run_tx(1'b0, 32'h400, 32'h0,       4'b1111, 0, "ld_range");
        run_tx(1'b0, 32'h10, 32'h0,        4'b1111, 5, "ld_backpressure");

        // Reset during WAIT must abort the store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55555555; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("abort_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata}, 35'd0);
        @(negedge clk);
        reset = 1'b1;
        run_tx(1'b0, 32'h20, 32'h0, 4'b1111, 0, "ld_after_abort");

        for (int t = 0; t < 60; t++) begin
            word = 30'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) word = 30'(256 + $urandom_range(0, 5000));
            a = {word, 2'($urandom)};
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'b00;
            run_tx(1'($urandom), a, $urandom, be_tab[$urandom_range(0, 8)],
                   $urandom_range(0, 3), "rand");
        end

        // Zero-wait build with rsp_ready tied high: ready must toggle 1,0,1.
        for (int t = 0; t < 6; t++) begin
            v = $urandom;
            @(negedge clk);
            check_eq("zero_ready_idle", 64'(z_req_ready), 64'd1);
            z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h0C; z_req_wdata = v; z_req_be = 4'hF;
            @(posedge clk); #1;
            z_req_we = 1'b0;
            @(negedge clk);
            check_eq("zero_store_rsp", {z_req_ready, z_rsp_valid, z_rsp_err, z_rsp_rdata},
                     {1'b0, 1'b1, 1'b0, 32'd0});
            @(negedge clk);
            check_eq("zero_ready_back", {z_req_ready, z_rsp_valid}, 2'b10);
            @(negedge clk);
            check_eq("zero_load_rsp", {z_req_ready, z_rsp_valid, z_rsp_err, z_rsp_rdata},
                     {1'b0, 1'b1, 1'b0, v});
            z_req_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
